// File: rtl/dac_pkg.sv
// Shared widths and state encoding for the DAC burst sequencer.
// Imported by the sequencer top and its helpers.
package dac_pkg;

  localparam int DEF_DLY_W = 32;
  localparam int DEF_AW    = 13;
  localparam int DEF_REP_W = 8;
  localparam int DEF_GAP_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_BURST = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchroniser for an async strobe with a one-cycle
// rising-edge pulse taken from the two settled stages.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_async,
  output logic o_rise
);

  logic [2:0] z_sync_q;
  logic [2:0] z_sync_d;

  always_comb begin
    z_sync_d = {z_sync_q[1:0], i_async};
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      z_sync_q <= '0;
    end else begin
      z_sync_q <= z_sync_d;
    end
  end

  assign o_rise = z_sync_q[1] & ~z_sync_q[2];

endmodule

// File: rtl/dac_burst_seq.sv
// Trigger / delay / burst sequencer feeding the DAC waveform RAM.
// Produces read address, sample window, busy/done and overrun status.
module dac_burst_seq
  import dac_pkg::*;
#(
  parameter int DLY_W = DEF_DLY_W,
  parameter int AW    = DEF_AW,
  parameter int REP_W = DEF_REP_W,
  parameter int GAP_W = DEF_GAP_W
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_sync,
  input  logic             i_soft_trig,
  input  logic [DLY_W-1:0] i_delay,
  input  logic [AW-1:0]    i_len,
  input  logic [REP_W-1:0] i_reps,
  input  logic [GAP_W-1:0] i_gap,
  input  logic             i_ovr_clr,
  output logic [AW-1:0]    o_addr,
  output logic             o_active,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ovr,
  output logic [15:0]      o_trig_cnt
);

  logic ext_trig;
  logic trig;

  state_e           state_q,    state_d;
  logic [DLY_W-1:0] dly_cnt_q,  dly_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q,  gap_cnt_d;
  logic [REP_W-1:0] rep_cnt_q,  rep_cnt_d;
  logic [AW-1:0]    len_q,      len_d;
  logic [REP_W-1:0] reps_q,     reps_d;
  logic [GAP_W-1:0] gap_q,      gap_d;
  logic [AW-1:0]    addr_q,     addr_d;
  logic             active_q,   active_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;
  logic             ovr_q,      ovr_d;
  logic [15:0]      trig_cnt_q, trig_cnt_d;

  sync_edge_det u_sync (
    .i_clk   (i_clk),
    .i_clr   (i_clr),
    .i_async (i_sync),
    .o_rise  (ext_trig)
  );

  assign trig = (ext_trig | i_soft_trig) & i_en;

  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    len_d      = len_q;
    reps_d     = reps_q;
    gap_d      = gap_q;
    addr_d     = addr_q;
    active_d   = active_q;
    done_d     = 1'b0;
    ovr_d      = ovr_q;
    trig_cnt_d = trig_cnt_q;

    // A trigger that cannot be accepted beats a same-cycle clear.
    if (trig && (state_q != ST_IDLE)) begin
      ovr_d = 1'b1;
    end else if (i_ovr_clr) begin
      ovr_d = 1'b0;
    end

    if (!i_en) begin
      state_d  = ST_IDLE;
      active_d = 1'b0;
      addr_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trig) begin
            len_d      = i_len;
            reps_d     = i_reps;
            gap_d      = i_gap;
            rep_cnt_d  = '0;
            trig_cnt_d = trig_cnt_q + 16'd1;
            if (i_delay == '0) begin
              state_d  = ST_BURST;
              active_d = 1'b1;
              addr_d   = '0;
            end else begin
              state_d   = ST_DELAY;
              dly_cnt_d = i_delay - DLY_W'(1);
            end
          end
        end
        ST_DELAY: begin
          if (dly_cnt_q == '0) begin
            state_d  = ST_BURST;
            active_d = 1'b1;
            addr_d   = '0;
          end else begin
            dly_cnt_d = dly_cnt_q - DLY_W'(1);
          end
        end
        ST_BURST: begin
          if (addr_q == len_q) begin
            addr_d = '0;
            if (rep_cnt_q < reps_q) begin
              rep_cnt_d = rep_cnt_q + REP_W'(1);
              if (gap_q != '0) begin
                state_d   = ST_GAP;
                active_d  = 1'b0;
                gap_cnt_d = gap_q - GAP_W'(1);
              end
            end else begin
              state_d  = ST_IDLE;
              active_d = 1'b0;
              done_d   = 1'b1;
            end
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            state_d  = ST_BURST;
            active_d = 1'b1;
            addr_d   = '0;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
          end
        end
        default: begin
          state_d  = ST_IDLE;
          active_d = 1'b0;
          addr_d   = '0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      state_q    <= ST_IDLE;
      dly_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      rep_cnt_q  <= '0;
      len_q      <= '0;
      reps_q     <= '0;
      gap_q      <= '0;
      addr_q     <= '0;
      active_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovr_q      <= 1'b0;
      trig_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      len_q      <= len_d;
      reps_q     <= reps_d;
      gap_q      <= gap_d;
      addr_q     <= addr_d;
      active_q   <= active_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovr_q      <= ovr_d;
      trig_cnt_q <= trig_cnt_d;
    end
  end

  assign o_addr     = addr_q;
  assign o_active   = active_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_ovr      = ovr_q;
  assign o_trig_cnt = trig_cnt_q;

endmodule
